// File: rtl/spi_dma_regs_pkg.sv
// rtl/spi_dma_regs_pkg.sv - register map constants and helpers for the spi_dma AXI4-Lite register file
package spi_dma_regs_pkg;

  localparam logic [3:0] CTRL_OFS     = 4'h0;
  localparam logic [3:0] STATUS_OFS   = 4'h4;
  localparam logic [3:0] DMA_ADDR_OFS = 4'h8;
  localparam logic [3:0] DMA_LEN_OFS  = 4'hC;

  localparam int ENABLE_BIT = 0;
  localparam int START_BIT  = 1;
  localparam int IRQ_EN_BIT = 2;
  localparam int BUSY_BIT   = 0;
  localparam int DONE_BIT   = 1;

  localparam int         DMA_LEN_W = 24;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_STATUS   = 2'd1,
    REG_DMA_ADDR = 2'd2,
    REG_DMA_LEN  = 2'd3
  } reg_sel_e;

  // Byte lane address bits are ignored; every word offset is mapped.
  function automatic reg_sel_e decode(input logic [3:0] addr);
    case (addr & 4'hC)
      CTRL_OFS:     return REG_CTRL;
      STATUS_OFS:   return REG_STATUS;
      DMA_ADDR_OFS: return REG_DMA_ADDR;
      DMA_LEN_OFS:  return REG_DMA_LEN;
      default:      return REG_CTRL;
    endcase
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/spi_dma_axil_regs_if.sv
// rtl/spi_dma_axil_regs_if.sv - AXI4-Lite bus bundle between the PS master and the spi_dma register file
interface spi_dma_axil_regs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/spi_dma_axil_regs.sv
// rtl/spi_dma_axil_regs.sv - AXI4-Lite register file driving the spi_dma engine and its level IRQ
module spi_dma_axil_regs
  import spi_dma_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  spi_dma_axil_regs_if.slave   s_axi,
  output logic                 ctrl_enable,
  output logic                 ctrl_start,
  output logic [31:0]          dma_addr,
  output logic [DMA_LEN_W-1:0] dma_len,
  input  logic                 sts_busy,
  input  logic                 sts_done,
  output logic                 irq
);

  logic                            live;
  logic                            aw_full, w_full, bvalid_q, rvalid_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q, cm_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q, cm_data, rdata_q, rd_mux;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_q, cm_strb;
  logic                            aw_hs, w_hs, ar_hs, commit, wr_ctrl, wr_status;
  reg_sel_e                        cm_sel;
  logic                            irq_en_q, done_q;
  logic                            unused_prot;

  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  // Ready outputs stay low until the first clock after reset release.
  assign s_axi.awready = live & ~aw_full & ~bvalid_q;
  assign s_axi.wready  = live & ~w_full & ~bvalid_q;
  assign s_axi.arready = live & ~rvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

  assign aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_hs  = s_axi.wvalid & s_axi.wready;
  assign ar_hs = s_axi.arvalid & s_axi.arready;

  // Commit as soon as both halves are available, either held or arriving now.
  assign commit    = (aw_full | aw_hs) & (w_full | w_hs);
  assign cm_addr   = aw_full ? aw_addr_q : s_axi.awaddr;
  assign cm_data   = w_full ? w_data_q : s_axi.wdata;
  assign cm_strb   = w_full ? w_strb_q : s_axi.wstrb;
  assign cm_sel    = decode(cm_addr);
  assign wr_ctrl   = commit & (cm_sel == REG_CTRL) & cm_strb[0];
  assign wr_status = commit & (cm_sel == REG_STATUS) & cm_strb[0];

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      live      <= 1'b0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      live <= 1'b1;
      if (commit) begin
        aw_full <= 1'b0;
      end else if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s_axi.awaddr;
      end
      if (commit) begin
        w_full <= 1'b0;
      end else if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
      if (commit)
        bvalid_q <= 1'b1;
      else if (s_axi.bready)
        bvalid_q <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (decode(s_axi.araddr))
      REG_CTRL: begin
        rd_mux[ENABLE_BIT] = ctrl_enable;
        rd_mux[IRQ_EN_BIT] = irq_en_q;
      end
      REG_STATUS: begin
        rd_mux[BUSY_BIT] = sts_busy;
        rd_mux[DONE_BIT] = done_q;
      end
      REG_DMA_ADDR: rd_mux = dma_addr;
      REG_DMA_LEN:  rd_mux[DMA_LEN_W-1:0] = dma_len;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_enable <= 1'b0;
      ctrl_start  <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      irq         <= 1'b0;
      dma_addr    <= '0;
      dma_len     <= '0;
    end else begin
      ctrl_start <= wr_ctrl & cm_data[START_BIT] & ~sts_busy;
      irq        <= irq_en_q & done_q;
      if (wr_ctrl) begin
        ctrl_enable <= cm_data[ENABLE_BIT];
        irq_en_q    <= cm_data[IRQ_EN_BIT];
      end
      // A completion arriving with a W1C clear must not be lost.
      if (sts_done)
        done_q <= 1'b1;
      else if (wr_status & cm_data[DONE_BIT])
        done_q <= 1'b0;
      if (commit && cm_sel == REG_DMA_ADDR)
        dma_addr <= apply_strb(dma_addr, cm_data, cm_strb);
      if (commit && cm_sel == REG_DMA_LEN)
        dma_len <= DMA_LEN_W'(apply_strb({{(32-DMA_LEN_W){1'b0}}, dma_len}, cm_data, cm_strb));
    end
  end

endmodule

// File: tb/tb_spi_dma_axil_regs.sv
// tb/tb_spi_dma_axil_regs.sv - directed bench for the spi_dma AXI4-Lite register file
module tb_spi_dma_axil_regs;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sts_busy = 1'b0;
  logic        sts_done = 1'b0;
  logic        ctrl_enable, ctrl_start, irq;
  logic [31:0] dma_addr;
  logic [23:0] dma_len;
  int          errors = 0;
  int          checks = 0;
  int          start_cnt = 0;

  spi_dma_axil_regs_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  spi_dma_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus),
    .ctrl_enable   (ctrl_enable),
    .ctrl_start    (ctrl_start),
    .dma_addr      (dma_addr),
    .dma_len       (dma_len),
    .sts_busy      (sts_busy),
    .sts_done      (sts_done),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ctrl_start) start_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b();
    int n = 0;
    while (!bus.bvalid && n < 50) begin tick(); n++; end
    if (!bus.bvalid) timeout("bvalid");
    else tick();
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_ok = 0, w_ok = 0;
    int n = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    while (!(aw_ok && w_ok) && n < 50) begin
      bit aw_now, w_now;
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      tick(); n++;
      if (aw_now) begin aw_ok = 1; bus.awvalid = 1'b0; end
      if (w_now)  begin w_ok = 1;  bus.wvalid = 1'b0; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (!(aw_ok && w_ok)) timeout("write_handshake");
    else wait_b();
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    d = 'x;
    bus.araddr = a; bus.arvalid = 1'b1;
    while (!bus.arready && n < 50) begin tick(); n++; end
    if (!bus.arready) begin
      bus.arvalid = 1'b0;
      timeout("arready");
      return;
    end
    tick();
    bus.arvalid = 1'b0;
    check("rvalid_latency", bus.rvalid, 1);
    d = bus.rdata;
    if (bus.rready) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, bus.awready, 0);
    check({tag, "_wready"}, bus.wready, 0);
    check({tag, "_arready"}, bus.arready, 0);
    check({tag, "_bvalid"}, bus.bvalid, 0);
    check({tag, "_rvalid"}, bus.rvalid, 0);
    check({tag, "_rdata"}, bus.rdata, 0);
    check({tag, "_outs"}, {28'h0, ctrl_enable, ctrl_start, irq, 1'b0}, 0);
    check({tag, "_dma_addr"}, dma_addr, 0);
    check({tag, "_dma_len"}, dma_len, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v[10];
    logic [31:0] rd, first;
    int          s0, n;
    bit          ok;

    v[0] = '{4'h8, 32'h11223344, 4'hF, 32'h11223344};
    v[1] = '{4'h8, 32'h000000AA, 4'h1, 32'h112233AA};
    v[2] = '{4'h8, 32'hDEADBEEF, 4'h6, 32'h11ADBEAA};
    v[3] = '{4'hC, 32'hFF000010, 4'hF, 32'h00000010};
    v[4] = '{4'hC, 32'h00ABCDEF, 4'h4, 32'h00AB0010};
    v[5] = '{4'h0, 32'h00000005, 4'hF, 32'h00000005};
    v[6] = '{4'h0, 32'hFFFFFFFF, 4'h0, 32'h00000005};
    v[7] = '{4'h0, 32'h00000000, 4'hF, 32'h00000000};
    v[8] = '{4'h4, 32'h00000001, 4'hF, 32'h00000000};
    v[9] = '{4'hB, 32'h12345678, 4'hF, 32'h12345678};

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

    tick(); tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(); tick();

    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      axi_write(v[i].addr, v[i].wdata, v[i].strb);
      axi_read(v[i].addr, rd);
      check($sformatf("vec%0d_rd", i), rd, v[i].exp);
    end
    check("vec_no_start", start_cnt - s0, 0);
    check("vec_dma_addr_out", dma_addr, 32'h12345678);
    check("vec_dma_len_out", dma_len, 24'hAB0010);

    // AW three cycles ahead of W
    bus.awaddr = 4'hC; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin tick(); n++; end
    tick();
    bus.awvalid = 1'b0;
    tick(); tick();
    check("awfirst_no_bvalid", bus.bvalid, 0);
    bus.wdata = 32'h0000000A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    check("awfirst_wready", bus.wready, 1);
    tick();
    bus.wvalid = 1'b0;
    check("awfirst_bvalid", bus.bvalid, 1);
    check("awfirst_dma_len", dma_len, 24'h00000A);
    tick();
    axi_write(4'hC, 32'hFF000010, 4'hF);
    axi_read(4'hC, rd);
    check("len_upper_masked", rd, 32'h00000010);

    // START pulse gated by busy
    s0 = start_cnt;
    axi_write(4'h0, 32'h3, 4'hF);
    tick(); tick();
    check("start_pulse_cnt", start_cnt - s0, 1);
    check("ctrl_enable", ctrl_enable, 1);
    axi_read(4'h0, rd);
    check("ctrl_rd", rd, 32'h1);
    sts_busy = 1'b1;
    s0 = start_cnt;
    axi_write(4'h0, 32'h3, 4'hF);
    tick(); tick();
    check("start_busy_dropped", start_cnt - s0, 0);
    sts_busy = 1'b0;

    // DONE / IRQ
    axi_write(4'h0, 32'h4, 4'hF);
    sts_done = 1'b1; tick(); sts_done = 1'b0;
    tick();
    check("irq_set", irq, 1);
    axi_read(4'h4, rd);
    check("status_done", rd, 32'h2);
    bus.awaddr = 4'h4; bus.wdata = 32'h2; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; sts_done = 1'b1;
    check("same_cycle_ready", {bus.awready, bus.wready}, 2'b11);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; sts_done = 1'b0;
    check("same_cycle_bvalid", bus.bvalid, 1);
    tick();
    axi_read(4'h4, rd);
    check("done_set_wins", rd, 32'h2);
    check("irq_still_set", irq, 1);
    axi_write(4'h4, 32'h2, 4'hF);
    tick(); tick();
    check("irq_cleared", irq, 0);
    axi_read(4'h4, rd);
    check("status_cleared", rd, 32'h0);

    // Backpressure on B and R
    bus.bready = 1'b0;
    bus.awaddr = 4'h8; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    check("bp_idle_ready", {bus.awready, bus.wready}, 2'b11);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.bvalid && !bus.awready && !bus.wready)) ok = 0;
      tick();
    end
    check("b_hold", ok, 1);
    bus.bready = 1'b1;
    tick();
    check("b_released", bus.bvalid, 0);
    bus.rready = 1'b0;
    bus.araddr = 4'h8; bus.arvalid = 1'b1;
    check("bp_arready", bus.arready, 1);
    tick();
    bus.arvalid = 1'b0;
    first = bus.rdata;
    check("r_hold_data", first, 32'hCAFEF00D);
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.rvalid && !bus.arready && bus.rdata === first)) ok = 0;
      tick();
    end
    check("r_hold", ok, 1);
    bus.rready = 1'b1;
    tick();
    check("r_released", bus.rvalid, 0);

    // Reset with AW held and W pending
    axi_write(4'h0, 32'h1, 4'hF);
    bus.awaddr = 4'hC; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin tick(); n++; end
    tick();
    bus.awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    axi_write(4'h8, 32'h00000055, 4'hF);
    axi_read(4'h8, rd);
    check("post_reset_addr", rd, 32'h00000055);
    axi_read(4'hC, rd);
    check("post_reset_len", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
